lcd_strobe_timer: RTL and testbench
===================================

// Module: lcd_strobe_timer
// PURPOSE
//   Programmable, fully synchronous strobe generator for the LCD interface. Drives
//   enable_lcd low for PERIOD cycles and then high for HIGH_LEN cycles, either once
//   (one-shot) or repeatedly (periodic). Run-time period and width, no derived clocks.
//   Sits between the LCD command sequencer and the LCD E pin.
// PARAMETERS
//   CNT_W    16  width of period/high_len inputs and the internal down-counter
//   PULSE_W  8   width of pulse_cnt (number of completed strobes, wraps)
// PORTS
//   clock         in   1        system clock; all logic on posedge
//   rst           in   1        synchronous, active-low reset
//   enable_count  in   1        run request; level-sensitive
//   one_shot      in   1        1 = single strobe then stop; 0 = periodic
//   period        in   CNT_W    low-phase length in cycles (0 treated as 1)
//   high_len      in   CNT_W    high-phase length in cycles (0 treated as 1)
//   enable_lcd    out  1        registered LCD enable strobe
//   tick          out  1        1-cycle pulse, coincident with first high cycle of enable_lcd
//   busy          out  1        1 whenever state != IDLE
//   done          out  1        1-cycle pulse when a one-shot or an abort finishes
//   pulse_cnt     out  PULSE_W  completed strobes since reset, wraps at 2^PULSE_W
// BEHAVIOUR
//   Reset (rst=0 at posedge): state=IDLE, counter=0, enable_lcd=0, tick=0, busy=0,
//     done=0, pulse_cnt=0. Reset takes priority over everything, including mid-phase.
//   States: IDLE, LOW, HIGH, FINISH.
//   IDLE: enable_lcd=0. enable_count=1 at edge N -> latch period, high_len,
//     one_shot (0 mapped to 1); counter <= period_l-1; go LOW. Inputs not re-sampled
//     until next IDLE exit.
//   LOW: counter decrements each cycle. At counter==0: if enable_count=1 -> go HIGH,
//     enable_lcd<=1, tick<=1, counter<=high_len_l-1; else -> FINISH.
//     enable_count=0 earlier in LOW -> FINISH on that edge (abort; no strobe issued).
//   Hence enable_lcd rises on edge N+period_l; low phase is exactly period_l cycles.
//   HIGH: enable_lcd held 1 for exactly high_len_l cycles; enable_count ignored
//     (no runt pulses). At counter==0: enable_lcd<=0, pulse_cnt<=pulse_cnt+1 (wrap);
//     if one_shot_l=1 or enable_count=0 -> FINISH; else counter<=period_l-1, go LOW.
//   Periodic waveform period = period_l + high_len_l cycles, duty high_len_l.
//   FINISH: done=1 for one cycle, enable_lcd=0, -> IDLE. Re-start requires IDLE
//     to see enable_count=1 (so minimum one FINISH + one IDLE cycle between runs).
//   tick is high only in the first cycle enable_lcd is high; done only in FINISH.
//   busy=1 in LOW, HIGH, FINISH; 0 in IDLE.
//   All outputs registered; no combinational path input->output.
//   Illegal state encoding -> IDLE with outputs at reset values.
// TESTING
//   1 period=4, high_len=2, one_shot=0, enable held 1 from edge 0 -> enable_lcd high
//     edges 4-5, 10-11, 16-17; tick at 4,10,16; pulse_cnt 1,2,3 after each fall.
//   2 one_shot=1, period=3, high_len=1 -> single high cycle at edge 3, done at edge 5,
//     busy low from edge 5 on, pulse_cnt=1 even with enable_count held.
//   3 period=0, high_len=0 -> treated as 1/1: enable_lcd toggles every cycle after
//     first rise, tick every 2 cycles.
//   4 abort: enable_count drops during LOW -> no strobe, done pulse next edge,
//     pulse_cnt unchanged; drop during HIGH (high_len=5) -> full 5-cycle pulse, then done.
//   5 rst=0 mid-HIGH -> next edge enable_lcd=0, busy=0, pulse_cnt=0; restart OK.
//   6 PULSE_W=2, periodic, 5 strobes -> pulse_cnt 1,2,3,0,1; change period mid-run
//     has no effect until next IDLE exit.

Source files
------------

// File: rtl/lcd_strobe_timer_if.sv
// Bundle of run controls and strobe status between the LCD command
// sequencer (master) and the strobe timer (slave).
interface lcd_strobe_timer_if #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8
);
  logic               enable_count;
  logic               one_shot;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   high_len;
  logic               enable_lcd;
  logic               tick;
  logic               busy;
  logic               done;
  logic [PULSE_W-1:0] pulse_cnt;

  modport master (
    output enable_count, one_shot, period, high_len,
    input  enable_lcd, tick, busy, done, pulse_cnt
  );

  modport slave (
    input  enable_count, one_shot, period, high_len,
    output enable_lcd, tick, busy, done, pulse_cnt
  );
endinterface

// File: rtl/lcd_strobe_timer.sv
// Programmable LCD E-pin strobe generator: PERIOD cycles low, HIGH_LEN cycles
// high, once or repeatedly. All outputs are registered.
module lcd_strobe_timer #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  lcd_strobe_timer_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     period_q;
  logic [CNT_W-1:0]     high_len_q;
  logic                 one_shot_q;
  logic                 enable_lcd_q;
  logic                 tick_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PULSE_W-1:0]   pulse_cnt_q;

  logic [CNT_W-1:0]     period_d;
  logic [CNT_W-1:0]     high_len_d;

  // Zero-length phases are stretched to one cycle before latching.
  always_comb begin
    period_d   = (bus.period   == '0) ? CNT_ONE : bus.period;
    high_len_d = (bus.high_len == '0) ? CNT_ONE : bus.high_len;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      high_len_q   <= '0;
      one_shot_q   <= 1'b0;
      enable_lcd_q <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pulse_cnt_q  <= '0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          enable_lcd_q <= 1'b0;
          if (bus.enable_count) begin
            period_q   <= period_d;
            high_len_q <= high_len_d;
            one_shot_q <= bus.one_shot;
            cnt_q      <= period_d - CNT_ONE;
            busy_q     <= 1'b1;
            state_q    <= LOW;
          end else begin
            busy_q <= 1'b0;
          end
        end
        LOW: begin
          // Dropping the run request while low aborts without a strobe.
          if (!bus.enable_count) begin
            state_q <= FINISH;
          end else if (cnt_q == '0) begin
            enable_lcd_q <= 1'b1;
            tick_q       <= 1'b1;
            cnt_q        <= high_len_q - CNT_ONE;
            state_q      <= HIGH;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        HIGH: begin
          // The high phase always runs to completion so no runt pulse reaches the LCD.
          if (cnt_q == '0) begin
            enable_lcd_q <= 1'b0;
            pulse_cnt_q  <= pulse_cnt_q + PULSE_ONE;
            if (one_shot_q || !bus.enable_count) begin
              state_q <= FINISH;
            end else begin
              cnt_q   <= period_q - CNT_ONE;
              state_q <= LOW;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        FINISH: begin
          enable_lcd_q <= 1'b0;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          enable_lcd_q <= 1'b0;
          tick_q       <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          pulse_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.enable_lcd = enable_lcd_q;
  assign bus.tick       = tick_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_lcd_strobe_timer.sv
// Scoreboard bench for lcd_strobe_timer: a timeline model predicts tick, fall
// and done events per run; a monitor pops and checks them as they appear.
module tb_lcd_strobe_timer;

  localparam int CW = 16;
  localparam int PW = 3;
  localparam int PM = 1 << PW;

  localparam int K_TICK = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          edge_n;
    int          pcnt;
    logic        busy;
    logic        lcd;
  } ev_t;

  logic clock = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pc_model = 0;
  bit   mon_en = 1'b0;
  ev_t  evq[$];

  lcd_strobe_timer_if #(.CNT_W(CW), .PULSE_W(PW)) bus ();

  lcd_strobe_timer #(.CNT_W(CW), .PULSE_W(PW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int sat1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic push_ev(input int k, input int e, input int pc, input logic b, input logic l);
    ev_t ev;
    ev.kind = k; ev.edge_n = e; ev.pcnt = pc; ev.busy = b; ev.lcd = l;
    evq.push_back(ev);
  endtask

  // Timeline of one run: s = edge that leaves IDLE, d = first edge that sees enable_count low.
  task automatic model_run(input int s, input int p, input int h, input bit os,
                           input int d, output int done_e);
    int pl, hl, base, rise, fall;
    pl = sat1(p);
    hl = sat1(h);
    base = s;
    while (1) begin
      if (d <= base + pl) begin
        done_e = ((d < base + 1) ? base + 1 : d) + 1;
        push_ev(K_DONE, done_e, pc_model, 1'b0, 1'b0);
        return;
      end
      rise = base + pl;
      push_ev(K_TICK, rise, pc_model, 1'b1, 1'b1);
      fall = rise + hl;
      pc_model = (pc_model + 1) % PM;
      push_ev(K_FALL, fall, pc_model, 1'b1, 1'b0);
      if (os || d <= fall) begin
        done_e = fall + 1;
        push_ev(K_DONE, done_e, pc_model, 1'b0, 1'b0);
        return;
      end
      base = fall;
    end
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    vectors++;
    if (evq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event kind=%0d edge=%0d: nothing expected", k, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.edge_n != cyc || e.pcnt != int'(bus.pulse_cnt) ||
          e.busy != bus.busy || e.lcd != bus.enable_lcd) begin
        miscompares++;
        $display("FAIL event: got kind=%0d edge=%0d pcnt=%0d busy=%0b lcd=%0b, want kind=%0d edge=%0d pcnt=%0d busy=%0b lcd=%0b",
                 k, cyc, bus.pulse_cnt, bus.busy, bus.enable_lcd,
                 e.kind, e.edge_n, e.pcnt, e.busy, e.lcd);
      end
    end
  endtask

  initial begin : monitor
    logic prev_lcd;
    logic fell;
    prev_lcd = 1'b0;
    forever begin
      @(negedge clock);
      fell = prev_lcd && !bus.enable_lcd;
      prev_lcd = bus.enable_lcd;
      if (mon_en) begin
        if (bus.tick) check_ev(K_TICK);
        if (fell)     check_ev(K_FALL);
        if (bus.done) check_ev(K_DONE);
      end
    end
  end

  // Inputs other than enable_count are scrambled while running to prove they are latched.
  task automatic do_run(input int p, input int h, input bit os, input int drel);
    int s, d, de;
    @(negedge clock);
    s = cyc + 1;
    d = s + drel;
    bus.enable_count = 1'b1;
    bus.period       = CW'(p);
    bus.high_len     = CW'(h);
    bus.one_shot     = os;
    model_run(s, p, h, os, d, de);
    while (cyc < de) begin
      @(negedge clock);
      if (cyc == d - 1) bus.enable_count = 1'b0;
      bus.period   = CW'($urandom_range(0, 7));
      bus.high_len = CW'($urandom_range(0, 7));
      bus.one_shot = 1'($urandom_range(0, 1));
    end
    bus.enable_count = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin : stimulus
    int p, h, drel, waited;
    bit os;
    rst = 1'b0;
    bus.enable_count = 1'b0;
    bus.one_shot = 1'b0;
    bus.period = '0;
    bus.high_len = '0;
    repeat (2) @(negedge clock);
    check_val("reset_outputs",
              int'({bus.enable_lcd, bus.tick, bus.busy, bus.done, bus.pulse_cnt}), 0);
    rst = 1'b1;
    mon_en = 1'b1;

    do_run(4, 2, 1'b0, 17);
    do_run(3, 1, 1'b1, 10);
    do_run(0, 0, 1'b0, 9);
    do_run(5, 2, 1'b0, 3);
    do_run(2, 5, 1'b0, 4);
    do_run(1, 1, 1'b0, 15);

    for (int unsigned i = 0; i < 40; i++) begin
      p = $urandom_range(0, 6);
      h = $urandom_range(0, 6);
      os = 1'($urandom_range(0, 1));
      drel = $urandom_range(1, 3 * (sat1(p) + sat1(h)) + 1);
      do_run(p, h, os, drel);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    check_val("queue_drained", evq.size(), 0);
    evq.delete();

    mon_en = 1'b0;
    @(negedge clock);
    bus.enable_count = 1'b1;
    bus.period = CW'(3);
    bus.high_len = CW'(5);
    bus.one_shot = 1'b0;
    waited = 0;
    while (!bus.enable_lcd && waited < 30) begin
      @(negedge clock);
      waited++;
    end
    check_val("reach_high_timeout", int'(bus.enable_lcd), 1);
    @(negedge clock);
    rst = 1'b0;
    bus.enable_count = 1'b0;
    @(negedge clock);
    check_val("midhigh_reset",
              int'({bus.enable_lcd, bus.tick, bus.busy, bus.done, bus.pulse_cnt}), 0);
    rst = 1'b1;
    pc_model = 0;
    @(negedge clock);
    mon_en = 1'b1;
    do_run(2, 3, 1'b1, 20);
    repeat (3) @(negedge clock);
    check_val("restart_drained", evq.size(), 0);
    check_val("restart_pulse_cnt", int'(bus.pulse_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
